// File: rtl/rapid_pkg.sv
// Shared types for the RAPID-X data-memory responder.
package rapid_pkg;

  localparam int unsigned RAPID_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } mem_resp_state_t;

  // Source of the read-data output register path.
  typedef enum logic [1:0] {
    RdZero = 2'd0,
    RdRam  = 2'd1,
    RdFwd  = 2'd2
  } rd_sel_t;

  // Wait counter width: $clog2(WAIT_STATES+1), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned wait_states);
    return (wait_states == 0) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/rapid_dmem_array.sv
// DEPTH x 32 synchronous RAM: one registered read and one write port, read returns old data
// on a same-address collision.
module rapid_dmem_array
  import rapid_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_re,
  input  logic [ADDR_W-1:0]       i_raddr,
  output logic [RAPID_WORD_W-1:0] o_rdata,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic [RAPID_WORD_W-1:0] i_wdata
);

  logic [RAPID_WORD_W-1:0] mem [DEPTH];
  logic [RAPID_WORD_W-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/rapid_dmem_responder.sv
// RAPID-X port2 data-memory responder: one word access at a time with programmable wait states.
// Define RAPID_DMEM_RANGE_CHECK_EN to flag misaligned / out-of-window accesses on o_error.
module rapid_dmem_responder
  import rapid_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [31:0]             i_address,
  input  logic [RAPID_WORD_W-1:0] i_write_data,
  output logic [RAPID_WORD_W-1:0] o_read_data,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_error
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES - 1);

  mem_resp_state_t         state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [RAPID_WORD_W-1:0] wdata_q, wdata_d;
  logic                    fault_q, fault_d;
  rd_sel_t                 rd_sel_q, rd_sel_d;
  logic [RAPID_WORD_W-1:0] fwd_data_q, fwd_data_d;

  logic                    accept;
  logic                    commit;
  logic                    fault_in;
  logic [ADDR_W-1:0]       new_idx;
  logic [RAPID_WORD_W-1:0] ram_rdata;

  assign new_idx = i_address[ADDR_W+1:2];

`ifdef RAPID_DMEM_RANGE_CHECK_EN
  assign fault_in = (i_address[1:0] != 2'b00) ||
                    ({1'b0, i_address} < {1'b0, BASE_ADDR}) ||
                    ({1'b0, i_address} >= ({1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4));
`else
  // Upper address bits alias; only the word index is decoded.
  logic unused_addr;
  assign unused_addr = ^i_address;
  assign fault_in    = 1'b0;
`endif

  // The captured write lands on the edge leaving RESPOND, unless reset abandons it.
  assign commit = (state_q == RESPOND) && we_q && !fault_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fault_d    = fault_q;
    rd_sel_d   = rd_sel_q;
    fwd_data_d = fwd_data_q;
    accept     = 1'b0;
    o_ready    = 1'b0;
    o_busy     = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept = i_req;
      end
      WAIT: begin
        o_busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        o_ready = 1'b1;
        accept  = i_req;
        o_busy  = i_req;
        if (!i_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      we_d       = i_we;
      addr_d     = new_idx;
      wdata_d    = i_write_data;
      fault_d    = fault_in;
      cnt_d      = CNT_INIT;
      state_d    = (WAIT_STATES > 0) ? WAIT : RESPOND;
      fwd_data_d = wdata_q;
      // A same-word read right behind a write must see the data being committed now.
      if (fault_in) begin
        rd_sel_d = RdZero;
      end else if (commit && (addr_q == new_idx)) begin
        rd_sel_d = RdFwd;
      end else begin
        rd_sel_d = RdRam;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
      rd_sel_q   <= RdZero;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
      rd_sel_q   <= rd_sel_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  rapid_dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .i_clk   (i_clk),
    .i_re    (accept && !i_reset),
    .i_raddr (new_idx),
    .o_rdata (ram_rdata),
    .i_we    (commit && !i_reset),
    .i_waddr (addr_q),
    .i_wdata (wdata_q)
  );

  always_comb begin
    o_read_data = '0;
    case (rd_sel_q)
      RdRam:   o_read_data = ram_rdata;
      RdFwd:   o_read_data = fwd_data_q;
      default: o_read_data = '0;
    endcase
  end

  assign o_error = o_ready && fault_q;

endmodule

// File: tb/tb_rapid_dmem_responder.sv
// Scoreboard bench for rapid_dmem_responder: one instance with no wait states, one with three.
module tb_rapid_dmem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        busy  [2];
  logic        err   [2];

  always #5 clk = ~clk;

  rapid_dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (0),
    .BASE_ADDR   (32'h0)
  ) u_dut0 (
    .i_clk        (clk),
    .i_reset      (rst[0]),
    .i_req        (req[0]),
    .i_we         (we[0]),
    .i_address    (addr[0]),
    .i_write_data (wdata[0]),
    .o_read_data  (rdata[0]),
    .o_ready      (ready[0]),
    .o_busy       (busy[0]),
    .o_error      (err[0])
  );

  rapid_dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_STATES (3),
    .BASE_ADDR   (32'h0)
  ) u_dut3 (
    .i_clk        (clk),
    .i_reset      (rst[1]),
    .i_req        (req[1]),
    .i_we         (we[1]),
    .i_address    (addr[1]),
    .i_write_data (wdata[1]),
    .o_read_data  (rdata[1]),
    .o_ready      (ready[1]),
    .o_busy       (busy[1]),
    .o_error      (err[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        chk;
    logic        err;
  } exp_t;

  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];
  logic [31:0] model  [int];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
`ifdef RAPID_DMEM_RANGE_CHECK_EN
    return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`else
    return (a === 32'hFFFF_FFFF);
`endif
  endfunction

  // Drive a request and record what its response must look like.
  task automatic issue(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit push, input bit commit);
    exp_t e;
    int   key;
    key = k * 1024 + int'(a[9:2]);
    if (is_fault(a)) begin
      e.rdata = 32'h0;
      e.chk   = 1'b1;
      e.err   = 1'b1;
    end else begin
      e.err   = 1'b0;
      e.chk   = model.exists(key);
      e.rdata = e.chk ? model[key] : 32'h0;
      if (w && commit) model[key] = d;
    end
    if (push) begin
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
  endtask

  task automatic wait_ready(input int k, input string tag);
    for (int i = 0; i < 40; i++) begin
      if (ready[k] === 1'b1) return;
      @(posedge clk); #1;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    issue(k, w, a, d, 1'b1, 1'b1);
    @(posedge clk); #1;
    req[k] = 1'b0;
    wait_ready(k, "access");
    @(posedge clk); #1;
  endtask

  // Write then hold the request line into RESPOND with a read.
  task automatic b2b(input int k, input logic [31:0] wa, input logic [31:0] d,
                     input logic [31:0] ra);
    issue(k, 1'b1, wa, d, 1'b1, 1'b1);
    @(posedge clk); #1;
    req[k] = 1'b0;
    wait_ready(k, "b2b_first");
    issue(k, 1'b0, ra, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    req[k] = 1'b0;
    if (k == 0) check("b2b_second_ready", 32'(ready[0]), 32'd1);
    wait_ready(k, "b2b_second");
    @(posedge clk); #1;
  endtask

  task automatic mon(input int k);
    exp_t e;
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      check(k == 0 ? "spurious_ready0" : "spurious_ready3", 32'd1, 32'd0);
    end else begin
      e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (e.chk) check(k == 0 ? "rdata0" : "rdata3", rdata[k], e.rdata);
      check(k == 0 ? "error0" : "error3", 32'(err[k]), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (ready[0] === 1'b1) mon(0);
    if (ready[1] === 1'b1) mon(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_ready", 32'(ready[k]), 32'd0);
      check("rst_busy",  32'(busy[k]),  32'd0);
      check("rst_error", 32'(err[k]),   32'd0);
      check("rst_rdata", rdata[k],      32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: pre-write data and single-cycle latency.
    access(0, 1'b1, 32'h10, 32'h1111_1111);
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    check("lat0_ready", 32'(ready[0]), 32'd1);
    @(posedge clk); #1;
    check("lat0_pulse", 32'(ready[0]), 32'd0);
    access(0, 1'b0, 32'h10, 32'h0);

    // Three wait states; a request during WAIT must be ignored.
    access(1, 1'b1, 32'h30, 32'h3030_3030);
    issue(1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("ws_c1_busy", 32'(busy[1]), 32'd1);
    check("ws_c1_ready", 32'(ready[1]), 32'd0);
    we[1] = 1'b1; wdata[1] = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check("ws_c2_busy", 32'(busy[1]), 32'd1);
    req[1] = 1'b0;
    @(posedge clk); #1;
    check("ws_c3_busy", 32'(busy[1]), 32'd1);
    check("ws_c3_ready", 32'(ready[1]), 32'd0);
    @(posedge clk); #1;
    check("ws_c4_ready", 32'(ready[1]), 32'd1);
    check("ws_c4_busy", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;
    check("ws_c5_ready", 32'(ready[1]), 32'd0);
    check("ws_c5_busy", 32'(busy[1]), 32'd0);
    access(1, 1'b0, 32'h30, 32'h0);

    // Back-to-back accesses, same word and a different word.
    for (int k = 0; k < 2; k++) begin
      b2b(k, 32'h20, 32'h5A5A_5A5A, 32'h20);
      access(k, 1'b1, 32'h10, 32'h0000_1010 + 32'(k));
      b2b(k, 32'h40, 32'h4040_4040, 32'h10);
      access(k, 1'b0, 32'h40, 32'h0);
    end

    // Reset during WAIT drops the write.
    access(1, 1'b1, 32'h8, 32'hAAAA_0008);
    issue(1, 1'b1, 32'h8, 32'h0000_1234, 1'b0, 1'b0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst[1] = 1'b1;
    check("rst_wait_busy", 32'(busy[1]), 32'd1);
    @(posedge clk); #1;
    check("rst_wait_ready", 32'(ready[1]), 32'd0);
    rst[1] = 1'b0;
    @(posedge clk); #1;
    check("rst_wait_idle", 32'(busy[1]), 32'd0);
    access(1, 1'b0, 32'h8, 32'h0);

    // Reset during RESPOND also drops the write.
    issue(1, 1'b1, 32'h8, 32'h0000_5555, 1'b1, 1'b0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    wait_ready(1, "rst_resp");
    rst[1] = 1'b1;
    @(posedge clk); #1;
    check("rst_resp_ready", 32'(ready[1]), 32'd0);
    rst[1] = 1'b0;
    @(posedge clk); #1;
    access(1, 1'b0, 32'h8, 32'h0);

    // Address range: aliasing by default, faults with the range check.
    access(0, 1'b1, 32'h0,   32'h00C0_FFEE);
    access(0, 1'b1, 32'h400, 32'hCAFE_0400);
    access(0, 1'b0, 32'h0,   32'h0);
    access(0, 1'b1, 32'h2,   32'h2222_2222);
    access(0, 1'b0, 32'h0,   32'h0);

    for (int i = 0; i < 100; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
